// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Optional bound checking (IFETCH_BOUND_CHK_EN) uses the FAULT state defined here.
package ifetch_pkg;

    localparam int XLEN    = 32;
    localparam int PC_STEP = 4;
    localparam int QDEPTH  = 2;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HALT  = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/ifetch_queue.sv
// Two-entry instruction FIFO between fetch and decode.
// The head register changes only on a pop or on a push into an empty queue, so it holds under stall.
module ifetch_queue
    import ifetch_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t push_entry,
    output fetch_entry_t head,
    output logic         valid,
    output logic [1:0]   count
);

    fetch_entry_t head_q;
    fetch_entry_t tail_q;
    logic [1:0]   count_q;

    // Flush beats push/pop; a pop on a flush edge simply counts as done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else if (flush) begin
            count_q <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) head_q <= push_entry;
                    else                 tail_q <= push_entry;
                    count_q <= count_q + 2'd1;
                end
                2'b01: begin
                    head_q  <= tail_q;
                    count_q <= count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        head_q <= push_entry;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= push_entry;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head  = head_q;
    assign valid = (count_q != 2'd0);
    assign count = count_q;

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch: PC, RUN/HALT FSM, zero-latency ROM access and a 2-entry decode queue.
// Define IFETCH_BOUND_CHK_EN to trap fetches beyond the ROM in a sticky FAULT state.
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter int               ADDR_BITS = 10,
    parameter logic [WIDTH-1:0] RESET_PC  = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] imem_addr,
    input  logic [WIDTH-1:0] imem_data,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    input  logic             halt_req,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_instr,
    output logic [WIDTH-1:0] out_pc,
    output logic             halted,
    output logic             fetch_fault
);

    localparam logic [WIDTH-1:0] PC_LIMIT = WIDTH'(PC_STEP) << ADDR_BITS;

    fetch_state_t     state, state_next;
    logic [WIDTH-1:0] pc, pc_next;
    fetch_entry_t     push_entry, head;
    logic             q_valid;
    logic [1:0]       q_count;
    logic             pop, redirect, fetch_ok, push, in_range;
    logic             unused_bits;

`ifdef IFETCH_BOUND_CHK_EN
    assign in_range    = (pc < PC_LIMIT);
    assign fetch_fault = (state == ST_FAULT);
`else
    assign in_range    = 1'b1;
    assign fetch_fault = 1'b0;
`endif

    assign unused_bits = ^{redirect_pc[1:0], PC_LIMIT};

    // A FAULT can only be cleared by reset, so redirects are ignored there.
    assign pop      = q_valid && out_ready;
    assign redirect = redirect_valid && (state != ST_FAULT);
    assign fetch_ok = (state == ST_RUN) && !redirect && ((q_count < 2'(QDEPTH)) || pop);
    assign push     = fetch_ok && in_range;

    assign push_entry.pc    = pc;
    assign push_entry.instr = imem_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_RUN;
            pc    <= RESET_PC;
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

    // Redirect outranks halt; the fetch on a halt edge still goes ahead.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        if (redirect) begin
            state_next = ST_RUN;
            pc_next    = {redirect_pc[WIDTH-1:2], 2'b00};
        end else begin
            if (push)
                pc_next = pc + WIDTH'(PC_STEP);
            if (fetch_ok && !in_range)
                state_next = ST_FAULT;
            else if ((state == ST_RUN) && halt_req)
                state_next = ST_HALT;
        end
    end

    ifetch_queue u_queue (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .pop        (pop),
        .flush      (redirect),
        .push_entry (push_entry),
        .head       (head),
        .valid      (q_valid),
        .count      (q_count)
    );

    assign imem_addr = pc;
    assign out_valid = q_valid;
    assign out_pc    = head.pc;
    assign out_instr = head.instr;
    assign halted    = (state == ST_HALT);

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed testbench for ifetch_unit; the ROM returns 32'hA000_0000 ^ address.
// Fault checks are compiled only when IFETCH_BOUND_CHK_EN is defined.
module tb_ifetch_unit;

    logic        clk;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt_req;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        halted;
    logic        fetch_fault;

    int total = 0;
    int bad   = 0;

    ifetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .halted         (halted),
        .fetch_fault    (fetch_fault)
    );

    assign imem_data = 32'hA000_0000 ^ imem_addr;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge and settle 1ns past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic rv, input logic [31:0] rpc, input logic hr, input logic rdy);
        redirect_valid = rv;
        redirect_pc    = rpc;
        halt_req       = hr;
        out_ready      = rdy;
    endtask

    task automatic do_reset(input logic rdy);
        applyStimulus(1'b0, 32'h0, 1'b0, rdy);
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        reset = 1'b1;
        #2;
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got %b want 0", out_valid); end
        total++; if (imem_addr !== 32'h0) begin bad++; $display("[TB] FAIL reset_addr got %h want 0", imem_addr); end
        total++; if (out_pc !== 32'h0 || out_instr !== 32'h0) begin bad++; $display("[TB] FAIL reset_head got %h/%h want 0/0", out_pc, out_instr); end
        total++; if (halted !== 1'b0 || fetch_fault !== 1'b0) begin bad++; $display("[TB] FAIL reset_flags got %b%b want 00", halted, fetch_fault); end
        step();
        reset = 1'b0;
    endtask

    task automatic test_stream();
        do_reset(1'b1);
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if (out_valid !== 1'b1 || out_pc !== 32'(i * 4) || out_instr !== (32'hA000_0000 ^ 32'(i * 4))) begin
                bad++;
                $display("[TB] FAIL stream_%0d got v=%b pc=%h instr=%h want v=1 pc=%h", i, out_valid, out_pc, out_instr, 32'(i * 4));
            end
        end
    endtask

    task automatic test_stall();
        do_reset(1'b0);
        for (int i = 0; i < 5; i++) step();
        total++; if (imem_addr !== 32'h8) begin bad++; $display("[TB] FAIL stall_addr got %h want 8", imem_addr); end
        total++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== 32'hA000_0000) begin bad++; $display("[TB] FAIL stall_head got v=%b pc=%h instr=%h want v=1 pc=0", out_valid, out_pc, out_instr); end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (out_valid !== 1'b1 || out_pc !== 32'(i * 4)) begin
                bad++;
                $display("[TB] FAIL stall_drain_%0d got v=%b pc=%h want v=1 pc=%h", i, out_valid, out_pc, 32'(i * 4));
            end
            step();
        end
    endtask

    task automatic test_redirect();
        do_reset(1'b0);
        step(); step(); step();
        out_ready = 1'b1;
        step();
        total++; if (out_pc !== 32'h4 || imem_addr !== 32'hC) begin bad++; $display("[TB] FAIL redir_pre got pc=%h addr=%h want 4/c", out_pc, imem_addr); end
        applyStimulus(1'b1, 32'h0000_0043, 1'b0, 1'b0);
        step();
        total++; if (out_valid !== 1'b0 || imem_addr !== 32'h40) begin bad++; $display("[TB] FAIL redir_flush got v=%b addr=%h want 0/40", out_valid, imem_addr); end
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        step();
        total++; if (out_valid !== 1'b1 || out_pc !== 32'h40 || out_instr !== 32'hA000_0040) begin bad++; $display("[TB] FAIL redir_first got v=%b pc=%h instr=%h want 1/40/a0000040", out_valid, out_pc, out_instr); end
        step();
        total++; if (out_pc !== 32'h44) begin bad++; $display("[TB] FAIL redir_second got %h want 44", out_pc); end
    endtask

    task automatic test_halt();
        do_reset(1'b1);
        for (int i = 0; i < 4; i++) step();
        total++; if (imem_addr !== 32'h10) begin bad++; $display("[TB] FAIL halt_pre got %h want 10", imem_addr); end
        halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        total++; if (halted !== 1'b1 || out_pc !== 32'h10 || out_valid !== 1'b1) begin bad++; $display("[TB] FAIL halt_enter got h=%b pc=%h v=%b want 1/10/1", halted, out_pc, out_valid); end
        step(); step();
        total++; if (out_valid !== 1'b0 || imem_addr !== 32'h14 || halted !== 1'b1) begin bad++; $display("[TB] FAIL halt_drain got v=%b addr=%h h=%b want 0/14/1", out_valid, imem_addr, halted); end
        applyStimulus(1'b1, 32'h0, 1'b0, 1'b1);
        step();
        total++; if (halted !== 1'b0 || imem_addr !== 32'h0) begin bad++; $display("[TB] FAIL halt_exit got h=%b addr=%h want 0/0", halted, imem_addr); end
        redirect_valid = 1'b0;
        step();
        total++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin bad++; $display("[TB] FAIL halt_resume got v=%b pc=%h want 1/0", out_valid, out_pc); end
    endtask

    task automatic test_back_to_back();
        do_reset(1'b1);
        step(); step();
        total++; if (out_pc !== 32'h4) begin bad++; $display("[TB] FAIL b2b_pre got %h want 4", out_pc); end
        applyStimulus(1'b1, 32'h20, 1'b1, 1'b1);
        step();
        total++; if (out_valid !== 1'b0 || halted !== 1'b0 || imem_addr !== 32'h20) begin bad++; $display("[TB] FAIL b2b_redir got v=%b h=%b addr=%h want 0/0/20", out_valid, halted, imem_addr); end
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        step();
        total++; if (out_valid !== 1'b1 || out_pc !== 32'h20) begin bad++; $display("[TB] FAIL b2b_first got v=%b pc=%h want 1/20", out_valid, out_pc); end
        step();
        total++; if (out_pc !== 32'h24) begin bad++; $display("[TB] FAIL b2b_second got %h want 24", out_pc); end
    endtask

    task automatic test_async_reset();
        do_reset(1'b0);
        step(); step();
        total++; if (out_valid !== 1'b1 || imem_addr !== 32'h8) begin bad++; $display("[TB] FAIL areset_pre got v=%b addr=%h want 1/8", out_valid, imem_addr); end
        #2;
        reset = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0 || imem_addr !== 32'h0 || out_pc !== 32'h0) begin bad++; $display("[TB] FAIL areset_now got v=%b addr=%h pc=%h want 0/0/0", out_valid, imem_addr, out_pc); end
        step();
        reset = 1'b0;
    endtask

`ifndef IFETCH_BOUND_CHK_EN
    task automatic test_wrap();
        do_reset(1'b1);
        applyStimulus(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1);
        step();
        redirect_valid = 1'b0;
        total++; if (imem_addr !== 32'hFFFF_FFFC) begin bad++; $display("[TB] FAIL wrap_addr got %h want fffffffc", imem_addr); end
        step();
        total++; if (out_pc !== 32'hFFFF_FFFC || out_instr !== 32'h5FFF_FFFC || imem_addr !== 32'h0) begin bad++; $display("[TB] FAIL wrap_fetch got pc=%h instr=%h addr=%h want fffffffc/5ffffffc/0", out_pc, out_instr, imem_addr); end
    endtask
`else
    task automatic test_bound();
        do_reset(1'b1);
        step();
        applyStimulus(1'b1, 32'h0000_1000, 1'b0, 1'b1);
        step();
        redirect_valid = 1'b0;
        total++; if (fetch_fault !== 1'b0 || imem_addr !== 32'h1000) begin bad++; $display("[TB] FAIL bound_pre got f=%b addr=%h want 0/1000", fetch_fault, imem_addr); end
        step();
        total++; if (fetch_fault !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("[TB] FAIL bound_fault got f=%b v=%b want 1/0", fetch_fault, out_valid); end
        applyStimulus(1'b1, 32'h0, 1'b0, 1'b1);
        step(); step();
        redirect_valid = 1'b0;
        total++; if (fetch_fault !== 1'b1 || out_valid !== 1'b0 || imem_addr !== 32'h1000) begin bad++; $display("[TB] FAIL bound_sticky got f=%b v=%b addr=%h want 1/0/1000", fetch_fault, out_valid, imem_addr); end
        do_reset(1'b1);
        total++; if (fetch_fault !== 1'b0) begin bad++; $display("[TB] FAIL bound_clear got %b want 0", fetch_fault); end
    endtask
`endif

    initial begin
        reset = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_halt();
        test_back_to_back();
        test_async_reset();
`ifndef IFETCH_BOUND_CHK_EN
        test_wrap();
`else
        test_bound();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
